apb_timer_slave: RTL and testbench
==================================

Name: apb_timer_slave

Overview:
- Zero-wait-state APB peripheral on the downstream side of the AHB-to-APB bridge. It consumes one of the bridge's three Pselx lines and drives Prdata back to the bridge.
- Provides a memory-mapped, prescaled 32-bit down-counter with one-shot/auto-reload modes, a sticky expiry flag and an interrupt.
- Includes an APB phase tracker that flags protocol violations. The bridge has no Pready, so every access must complete in setup+enable with no wait states.

Parameters:
- SEL_IDX, 0, index of the Pselx bit decoded by this slave (0..2).
- PRESCALE_W, 8, width of the CTRL prescale field and the prescaler counter.

Ports:
- Hclk  input  1  system clock; all state updates on rising edge.
- Hreset  input  1  asynchronous, active-high reset.
- Pselx  input  3  APB slave selects from the bridge; this slave uses Pselx[SEL_IDX].
- Penable  input  1  APB enable (access) phase.
- Pwrite  input  1  1 = write, 0 = read.
- Paddr  input  32  APB address; only Paddr[3:2] decoded, other bits ignored.
- Pwdata  input  32  APB write data.
- Prdata  output  32  APB read data, combinational.
- Irq  output  1  interrupt, = STATUS.EXPIRED & CTRL.IE.

Behaviour:
- Register map (Paddr[3:2]):
  - 0 CTRL: [0] EN, [1] RELOAD, [2] IE, [4+:PRESCALE_W] PRESCALE; other bits read 0.
  - 1 LOAD: 32-bit reload value.
  - 2 COUNT: read-only current count; writes ignored.
  - 3 STATUS: [0] EXPIRED (sticky, write-1-to-clear), [1] PERR (sticky, write-1-to-clear); other bits read 0.
- Reset values: all registers 0, prescaler 0, APB tracker in IDLE. Prdata = 0, Irq = 0.
- Write commit: on the rising edge where sel & Penable & Pwrite (sel = Pselx[SEL_IDX]), exactly one cycle per access.
- Read: Prdata = selected register whenever sel & ~Pwrite (both setup and enable phases); Prdata = 0 otherwise. No read side effects.
- APB tracker, states IDLE, SETUP, ACCESS:
  - IDLE -> SETUP on sel & ~Penable.
  - SETUP -> ACCESS on sel & Penable.
  - ACCESS -> SETUP on sel & ~Penable (back-to-back transfer); ACCESS -> IDLE on ~sel.
  - Penable high while in IDLE: set PERR, go to ACCESS, perform the access.
  - sel dropped while in SETUP: set PERR, go to IDLE.
  - Paddr/Pwrite/Pwdata are not required to be stable; the enable-phase value is used.
- Prescaler:
  - Counts only while EN = 1.
  - tick = (presc == PRESCALE); on tick presc <= 0, else presc + 1. PRESCALE = 0 gives a tick every cycle.
  - Cleared when EN is written 0->1 and on any LOAD write.
- Counter, on tick while EN = 1:
  - COUNT > 1: COUNT <= COUNT - 1.
  - COUNT == 1: EXPIRED <= 1. If RELOAD: COUNT <= LOAD. Else COUNT <= 0 and EN <= 0.
  - COUNT == 0: no change. EN stays 1, no expiry; a one-shot started from 0 never expires.
- LOAD write: LOAD and COUNT both take Pwdata the same edge.
- Priority rules:
  - LOAD write on a tick edge: the write wins; no decrement that edge.
  - STATUS W1C on the same edge as an EXPIRED/PERR set: the set wins.
  - CTRL write with EN = 1 on the same edge as a one-shot expiry auto-clears EN: the write wins, EN = 1.
- Expiry period: (PRESCALE+1)*LOAD cycles after EN rises.
- Irq is combinational from registers; there is no extra latency after EXPIRED sets.
- Hreset asserted mid-access or mid-count returns everything to reset values immediately (async). The first access after release starts from IDLE.

Test Plan:
- Reset then read all four offsets: Prdata = 0 each, Irq = 0, STATUS.PERR stays 0 for correct setup/enable sequences.
- Write LOAD = 5, CTRL = 0x5 (EN, IE, PRESCALE 0): COUNT reads 5,4,3,2,1 on consecutive cycles. EXPIRED and Irq rise exactly 5 cycles after the CTRL write edge; COUNT = 0, CTRL.EN reads 0.
- Write LOAD = 3, CTRL = 0x23 (EN, RELOAD, PRESCALE 2): EXPIRED sets after 9 cycles, COUNT reloads to 3, and the timer keeps running with period 9. Writing STATUS = 1 clears EXPIRED, unless the write coincides with an expiry edge, in which case EXPIRED stays 1.
- Write LOAD = 0x100 on the same edge a tick occurs: COUNT reads 0x100 the next cycle (no decrement), and the prescaler restarts from 0.
- Drive Penable = 1 with sel = 1 and no setup cycle: PERR sets and the write still commits. Writing STATUS = 2 clears PERR. Driving Pselx[SEL_IDX+1 mod 3]: no register change, Prdata = 0.
- Assert Hreset mid-count (COUNT = 0x40, EN = 1): all registers read 0 after release, and Irq drops asynchronously with Hreset.

Source files
------------

// File: rtl/apb_timer_slave.sv
// apb_timer_slave
//
// Zero-wait-state APB peripheral behind the AHB-to-APB bridge. It holds a
// prescaled 32-bit down-counter with one-shot and auto-reload modes, a sticky
// expiry flag with interrupt, and a phase tracker that flags APB protocol
// violations. The bridge has no Pready, so every access must complete in one
// setup cycle followed by one enable cycle.
//
// Register map (Paddr[3:2]):
//   0 CTRL   [0] EN, [1] RELOAD, [2] IE, [4 +: PRESCALE_W] PRESCALE
//   1 LOAD   reload value; a write also loads COUNT
//   2 COUNT  current count, read-only
//   3 STATUS [0] EXPIRED, [1] PERR, both sticky and write-1-to-clear
//
// Ports:
//   Hclk     in   system clock, rising edge
//   Hreset   in   asynchronous active-high reset
//   Pselx    in   [2:0] slave selects, this slave decodes Pselx[SEL_IDX]
//   Penable  in   APB enable (access) phase
//   Pwrite   in   1 = write, 0 = read
//   Paddr    in   [31:0] address, only [3:2] decoded
//   Pwdata   in   [31:0] write data
//   Prdata   out  [31:0] read data, combinational, zero when not reading
//   Irq      out  interrupt = EXPIRED & IE

module apb_timer_slave #(
  parameter int SEL_IDX    = 0,
  parameter int PRESCALE_W = 8
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Irq
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_t;

  apb_state_t state, state_nxt;

  logic                  sel;
  logic [1:0]            addr;
  logic                  wr;
  logic                  ctrl_wr;
  logic                  load_wr;
  logic                  status_wr;
  logic                  perr_set;

  logic                  en;
  logic                  reload;
  logic                  ie;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] presc;
  logic [31:0]           load_val;
  logic [31:0]           count;
  logic                  expired;
  logic                  perr;

  logic                  tick;
  logic                  expire;
  logic [31:0]           rd_data;

  // Address bits outside [3:2] and the other selects are intentionally ignored.
  logic                  unused_bits;
  assign unused_bits = ^{Pselx, Paddr[31:4], Paddr[1:0]};

  assign sel       = Pselx[SEL_IDX];
  assign addr      = Paddr[3:2];
  assign wr        = sel & Penable & Pwrite;
  assign ctrl_wr   = wr & (addr == 2'd0);
  assign load_wr   = wr & (addr == 2'd1);
  assign status_wr = wr & (addr == 2'd3);

  // A LOAD write on a tick edge takes precedence, so it also suppresses expiry.
  assign tick   = en & (presc == prescale);
  assign expire = tick & (count == 32'd1) & ~load_wr;

  // APB phase tracker: state register.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // APB phase tracker: next state. An enable without a setup cycle is still
  // treated as a real access, so it lands in ACCESS.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (sel & ~Penable)     state_nxt = SETUP;
        else if (sel & Penable) state_nxt = ACCESS;
      end
      SETUP: begin
        if (~sel)               state_nxt = IDLE;
        else if (Penable)       state_nxt = ACCESS;
      end
      ACCESS: begin
        if (~sel)               state_nxt = IDLE;
        else if (~Penable)      state_nxt = SETUP;
      end
      default:                  state_nxt = IDLE;
    endcase
  end

  // APB phase tracker: protocol error detection.
  always_comb begin
    perr_set = 1'b0;
    unique case (state)
      IDLE:    perr_set = sel & Penable;
      SETUP:   perr_set = ~sel;
      default: perr_set = 1'b0;
    endcase
  end

  // CTRL register. A one-shot expiry clears EN unless a CTRL write on the
  // same edge says otherwise.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      en       <= 1'b0;
      reload   <= 1'b0;
      ie       <= 1'b0;
      prescale <= '0;
    end else if (ctrl_wr) begin
      en       <= Pwdata[0];
      reload   <= Pwdata[1];
      ie       <= Pwdata[2];
      prescale <= Pwdata[4 +: PRESCALE_W];
    end else if (expire & ~reload) begin
      en       <= 1'b0;
    end
  end

  // Prescaler restarts on a LOAD write or when the timer is switched on, so
  // the first period is always a full (PRESCALE+1)*LOAD cycles.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      presc <= '0;
    end else if (load_wr | (ctrl_wr & Pwdata[0] & ~en)) begin
      presc <= '0;
    end else if (en) begin
      presc <= tick ? '0 : presc + PRESCALE_W'(1);
    end
  end

  // LOAD and COUNT. A count of zero holds, so a one-shot started from zero
  // never expires.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      load_val <= '0;
      count    <= '0;
    end else if (load_wr) begin
      load_val <= Pwdata;
      count    <= Pwdata;
    end else if (tick) begin
      if (count > 32'd1) begin
        count <= count - 32'd1;
      end else if (count == 32'd1) begin
        count <= reload ? load_val : 32'd0;
      end
    end
  end

  // Sticky STATUS flags; a set on the same edge as a clear wins.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      expired <= 1'b0;
      perr    <= 1'b0;
    end else begin
      expired <= expire   | (expired & ~(status_wr & Pwdata[0]));
      perr    <= perr_set | (perr    & ~(status_wr & Pwdata[1]));
    end
  end

  // Read mux, valid in both setup and enable phases of a read.
  always_comb begin
    rd_data = '0;
    unique case (addr)
      2'd0: begin
        rd_data[0]                = en;
        rd_data[1]                = reload;
        rd_data[2]                = ie;
        rd_data[4 +: PRESCALE_W]  = prescale;
      end
      2'd1: rd_data = load_val;
      2'd2: rd_data = count;
      2'd3: begin
        rd_data[0] = expired;
        rd_data[1] = perr;
      end
      default: rd_data = '0;
    endcase
  end

  assign Prdata = (sel & ~Pwrite) ? rd_data : 32'd0;
  assign Irq    = expired & ie;

endmodule

// File: tb/tb_apb_timer_slave.sv
// tb_apb_timer_slave
//
// Directed bench for apb_timer_slave. Inputs are driven 1 time unit after the
// rising edge; outputs are sampled a further unit later, between edges.

module tb_apb_timer_slave;

  localparam int SEL_IDX    = 0;
  localparam int PRESCALE_W = 8;
  localparam logic [2:0] MY_SEL    = 3'(1 << SEL_IDX);
  localparam logic [2:0] OTHER_SEL = 3'(1 << ((SEL_IDX + 1) % 3));

  logic        Hclk;
  logic        Hreset;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;
  logic        Irq;

  int total;
  int bad;

  logic [31:0] rdata;

  apb_timer_slave #(
    .SEL_IDX    (SEL_IDX),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .Hclk    (Hclk),
    .Hreset  (Hreset),
    .Pselx   (Pselx),
    .Penable (Penable),
    .Pwrite  (Pwrite),
    .Paddr   (Paddr),
    .Pwdata  (Pwdata),
    .Prdata  (Prdata),
    .Irq     (Irq)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  // Drive all APB inputs at once; address is a register index.
  task automatic applyStimulus(input logic [2:0] psel, input logic pen,
                               input logic pwr, input logic [1:0] idx,
                               input logic [31:0] data);
    Pselx   = psel;
    Penable = pen;
    Pwrite  = pwr;
    Paddr   = {28'h0, idx, 2'b00};
    Pwdata  = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Setup + enable write; returns 1 unit after the commit edge, bus idle.
  task automatic apbWrite(input logic [1:0] idx, input logic [31:0] data);
    applyStimulus(MY_SEL, 1'b0, 1'b1, idx, data);
    @(posedge Hclk); #1;
    applyStimulus(MY_SEL, 1'b1, 1'b1, idx, data);
    @(posedge Hclk); #1;
    applyStimulus(3'b000, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  // Setup + enable read; data is sampled in the setup phase.
  task automatic apbRead(input logic [1:0] idx, output logic [31:0] data);
    applyStimulus(MY_SEL, 1'b0, 1'b0, idx, 32'h0);
    #1;
    data = Prdata;
    @(posedge Hclk); #1;
    applyStimulus(MY_SEL, 1'b1, 1'b0, idx, 32'h0);
    @(posedge Hclk); #1;
    applyStimulus(3'b000, 1'b0, 1'b0, 2'd0, 32'h0);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    Hreset = 1'b1;
    applyStimulus(3'b000, 1'b0, 1'b0, 2'd0, 32'h0);
    #1;
    checkOutput("reset_prdata", Prdata, 32'h0);
    checkOutput("reset_irq", {31'h0, Irq}, 32'h0);
    repeat (2) @(negedge Hclk);
    Hreset = 1'b0;
    @(posedge Hclk); #1;

    // Reset values of all registers.
    apbRead(2'd0, rdata); checkOutput("rst_ctrl", rdata, 32'h0);
    apbRead(2'd1, rdata); checkOutput("rst_load", rdata, 32'h0);
    apbRead(2'd2, rdata); checkOutput("rst_count", rdata, 32'h0);
    apbRead(2'd3, rdata); checkOutput("rst_status", rdata, 32'h0);
    apbRead(2'd3, rdata); checkOutput("no_perr_clean", rdata, 32'h0);

    // One-shot, LOAD=5, prescale 0; CTRL commit edge is E0.
    apbWrite(2'd1, 32'd5);
    apbWrite(2'd0, 32'h5);
    applyStimulus(MY_SEL, 1'b0, 1'b0, 2'd2, 32'h0);
    #1;
    checkOutput("os_count0", Prdata, 32'd5);
    for (int k = 1; k <= 4; k++) begin
      @(posedge Hclk); #1;
      applyStimulus(MY_SEL, (k % 2 == 1), 1'b0, 2'd2, 32'h0);
      #1;
      checkOutput($sformatf("os_count%0d", k), Prdata, 32'(5 - k));
    end
    checkOutput("os_irq_early", {31'h0, Irq}, 32'h0);
    @(posedge Hclk); #1;
    applyStimulus(MY_SEL, 1'b1, 1'b0, 2'd3, 32'h0);
    #1;
    checkOutput("os_irq_e5", {31'h0, Irq}, 32'h1);
    checkOutput("os_status_e5", Prdata, 32'h1);
    @(posedge Hclk); #1;
    applyStimulus(3'b000, 1'b0, 1'b0, 2'd0, 32'h0);
    apbRead(2'd2, rdata); checkOutput("os_count_end", rdata, 32'h0);
    apbRead(2'd0, rdata); checkOutput("os_ctrl_en_off", rdata, 32'h4);
    apbWrite(2'd3, 32'h1);
    checkOutput("os_irq_cleared", {31'h0, Irq}, 32'h0);

    // Auto-reload, LOAD=3, prescale 2: expiry every 9 cycles (E9, E18, ...).
    apbWrite(2'd1, 32'd3);
    apbWrite(2'd0, 32'h23);
    repeat (8) @(posedge Hclk);
    #1;
    applyStimulus(MY_SEL, 1'b0, 1'b0, 2'd3, 32'h0);
    #1;
    checkOutput("rl_status_e8", Prdata, 32'h0);
    @(posedge Hclk); #1;
    applyStimulus(MY_SEL, 1'b1, 1'b0, 2'd3, 32'h0);
    #1;
    checkOutput("rl_status_e9", Prdata, 32'h1);
    applyStimulus(MY_SEL, 1'b1, 1'b0, 2'd2, 32'h0);
    #1;
    checkOutput("rl_count_reload", Prdata, 32'd3);
    @(posedge Hclk); #1;
    applyStimulus(3'b000, 1'b0, 1'b0, 2'd0, 32'h0);
    apbWrite(2'd3, 32'h1);                       // commits at E12
    apbRead(2'd3, rdata); checkOutput("rl_w1c", rdata, 32'h0);
    repeat (2) @(posedge Hclk);
    #1;
    apbWrite(2'd3, 32'h1);                       // commits at E18, an expiry edge
    apbRead(2'd3, rdata); checkOutput("rl_set_beats_clr", rdata, 32'h1);

    // LOAD write on tick edge E24: no decrement, prescaler restarts.
    repeat (2) @(posedge Hclk);
    #1;
    apbWrite(2'd1, 32'h100);
    apbRead(2'd2, rdata); checkOutput("ld_tick_count", rdata, 32'h100);
    apbRead(2'd2, rdata); checkOutput("ld_presc_hold", rdata, 32'h100);
    apbRead(2'd2, rdata); checkOutput("ld_next_tick", rdata, 32'hFF);
    apbWrite(2'd0, 32'h0);
    apbWrite(2'd3, 32'h3);
    apbRead(2'd3, rdata); checkOutput("status_clear", rdata, 32'h0);

    // Enable without setup: PERR sets and the write still commits.
    @(posedge Hclk); #1;
    applyStimulus(MY_SEL, 1'b1, 1'b1, 2'd1, 32'h55);
    @(posedge Hclk); #1;
    applyStimulus(3'b000, 1'b0, 1'b0, 2'd0, 32'h0);
    @(posedge Hclk); #1;
    apbRead(2'd3, rdata); checkOutput("perr_noset", rdata, 32'h2);
    apbRead(2'd1, rdata); checkOutput("perr_load", rdata, 32'h55);
    apbRead(2'd2, rdata); checkOutput("perr_count", rdata, 32'h55);
    apbWrite(2'd3, 32'h2);
    apbRead(2'd3, rdata); checkOutput("perr_w1c", rdata, 32'h0);

    // Select dropped during setup.
    applyStimulus(MY_SEL, 1'b0, 1'b1, 2'd1, 32'h0);
    @(posedge Hclk); #1;
    applyStimulus(3'b000, 1'b0, 1'b0, 2'd0, 32'h0);
    @(posedge Hclk); #1;
    apbRead(2'd3, rdata); checkOutput("perr_drop", rdata, 32'h2);
    apbWrite(2'd3, 32'h2);

    // Another slave's select: no write, no read data.
    applyStimulus(OTHER_SEL, 1'b0, 1'b1, 2'd1, 32'h77);
    @(posedge Hclk); #1;
    applyStimulus(OTHER_SEL, 1'b1, 1'b1, 2'd1, 32'h77);
    @(posedge Hclk); #1;
    applyStimulus(OTHER_SEL, 1'b0, 1'b0, 2'd1, 32'h0);
    #1;
    checkOutput("other_sel_prdata", Prdata, 32'h0);
    @(posedge Hclk); #1;
    applyStimulus(OTHER_SEL, 1'b1, 1'b0, 2'd1, 32'h0);
    @(posedge Hclk); #1;
    applyStimulus(3'b000, 1'b0, 1'b0, 2'd0, 32'h0);
    apbRead(2'd1, rdata); checkOutput("other_sel_load", rdata, 32'h55);
    apbRead(2'd3, rdata); checkOutput("other_sel_status", rdata, 32'h0);

    // Reset mid-count with Irq high.
    apbWrite(2'd1, 32'd1);
    apbWrite(2'd0, 32'h7);
    apbWrite(2'd0, 32'hFF7);
    apbWrite(2'd1, 32'h40);
    apbRead(2'd2, rdata); checkOutput("mid_count", rdata, 32'h40);
    checkOutput("mid_irq", {31'h0, Irq}, 32'h1);
    applyStimulus(MY_SEL, 1'b0, 1'b0, 2'd2, 32'h0);
    #2;
    Hreset = 1'b1;
    #1;
    checkOutput("async_irq_drop", {31'h0, Irq}, 32'h0);
    checkOutput("async_prdata", Prdata, 32'h0);
    applyStimulus(3'b000, 1'b0, 1'b0, 2'd0, 32'h0);
    @(negedge Hclk);
    Hreset = 1'b0;
    @(posedge Hclk); #1;
    apbRead(2'd0, rdata); checkOutput("post_ctrl", rdata, 32'h0);
    apbRead(2'd1, rdata); checkOutput("post_load", rdata, 32'h0);
    apbRead(2'd2, rdata); checkOutput("post_count", rdata, 32'h0);
    apbRead(2'd3, rdata); checkOutput("post_status", rdata, 32'h0);
    checkOutput("post_irq", {31'h0, Irq}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
